// File: rtl/segmentos_7_seq_pkg.sv
// Shared types and constants for the serial binary-to-BCD 7-segment display driver.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package segmentos_7_seq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic int unsigned pow10(input int n);
        int unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // Accumulator digits: ceil(w*log10(2))+1, never fewer than the displayed digits.
    function automatic int acc_digits(input int w, input int d);
        int a;
        a = (w * 30103 + 99999) / 100000 + 1;
        return (a > d) ? a : d;
    endfunction

endpackage

// File: rtl/segmentos_7_seq_if.sv
// Conversion request/result bundle between a requester (master) and the display driver (slave).
interface segmentos_7_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    import segmentos_7_seq_pkg::*;

    // start is taken only while busy=0; done pulses one cycle with the new
    // bcd_out/hex_out/overflow, which then hold until the next done.
    logic                  start;
    logic [WIDTH-1:0]      bin_in;
    logic                  blank_en;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [7*DIGITS-1:0]   hex_out;
    state_e                state_dbg;

    modport master (
        output start, bin_in, blank_en,
        input  busy, done, overflow, bcd_out, hex_out, state_dbg
    );

    modport slave (
        input  start, bin_in, blank_en,
        output busy, done, overflow, bcd_out, hex_out, state_dbg
    );

endinterface

// File: rtl/segmentos_7_seq_bcd_seg_decode.sv
// One BCD digit to an active-low 7-segment pattern; dash wins over blank.
module bcd_seg_decode
    import segmentos_7_seq_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/segmentos_7_seq.sv
// Serial double-dabble converter: one input bit per cycle into BCD, then
// registered BCD digits and segment patterns with blanking and overflow dash.
module segmentos_7_seq
    import segmentos_7_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input logic              clk,
    input logic              rst_n,
    segmentos_7_seq_if.slave bus
);

    localparam int          ACC_D = acc_digits(WIDTH, DIGITS);
    localparam int          ACC_W = 4 * ACC_D;
    localparam int          CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [31:0] LIMIT = 32'(pow10(DIGITS));

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      shift_q, shift_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  mode_q, mode_d;
    logic                  ovf_pend_q, ovf_pend_d;
    logic                  done_q, done_d;
    logic                  overflow_q, overflow_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [7*DIGITS-1:0]   hex_q, hex_d;

    logic [ACC_W-1:0]      adj;
    logic [ACC_W-1:0]      acc_nx;
    logic [WIDTH-1:0]      shift_nx;
    logic [DIGITS-1:0]     blank_v;
    logic                  zero_above;
    logic [7*DIGITS-1:0]   seg_nx;

    // Add-3 on every nibble from the current value, then shift {bcd, bin} left.
    always_comb begin
        adj = acc_q;
        for (int i = 0; i < ACC_D; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
        {acc_nx, shift_nx} = {adj, shift_q} << 1;
    end

    // Digit i is blanked when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        blank_v    = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (acc_nx[4*i +: 4] == 4'd0);
            blank_v[i] = mode_q && zero_above;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        bcd_seg_decode u_dec (
            .bcd   (acc_nx[4*g +: 4]),
            .blank (blank_v[g]),
            .dash  (ovf_pend_q),
            .seg   (seg_nx[7*g +: 7])
        );
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        ovf_pend_d = ovf_pend_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        bcd_d      = bcd_q;
        hex_d      = hex_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    shift_d    = bus.bin_in;
                    mode_d     = bus.blank_en;
                    ovf_pend_d = (32'(bus.bin_in) >= LIMIT);
                    acc_d      = '0;
                    cnt_d      = CNT_W'(WIDTH - 1);
                    state_d    = ST_CONV;
                end
            end
            ST_CONV: begin
                acc_d   = acc_nx;
                shift_d = shift_nx;
                if (cnt_q == '0) begin
                    bcd_d      = acc_nx[4*DIGITS-1:0];
                    hex_d      = seg_nx;
                    overflow_d = ovf_pend_q;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            ovf_pend_q <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            bcd_q      <= '0;
            hex_q      <= '1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            ovf_pend_q <= ovf_pend_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            bcd_q      <= bcd_d;
            hex_q      <= hex_d;
        end
    end

    assign bus.busy      = (state_q == ST_CONV);
    assign bus.done      = done_q;
    assign bus.overflow  = overflow_q;
    assign bus.bcd_out   = bcd_q;
    assign bus.hex_out   = hex_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_segmentos_7_seq.sv
// Bench for segmentos_7_seq: an 8-bit/3-digit and a 10-bit/2-digit instance,
// directed vectors with hand-computed results checked by done-triggered monitors.
module tb_segmentos_7_seq;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    logic [33:0] exp_a_q[$];
    logic [22:0] exp_b_q[$];
    logic [33:0] ea;
    logic [22:0] eb;

    segmentos_7_seq_if #(.WIDTH(8),  .DIGITS(3)) ia ();
    segmentos_7_seq_if #(.WIDTH(10), .DIGITS(2)) ib ();

    segmentos_7_seq #(.WIDTH(8),  .DIGITS(3)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    segmentos_7_seq #(.WIDTH(10), .DIGITS(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (ia.done === 1'b1) begin
            if (exp_a_q.size() == 0) begin
                check("unexpected_done_a", 1, 0);
            end else begin
                ea = exp_a_q.pop_front();
                check("result_a", {ia.overflow, ia.bcd_out, ia.hex_out}, ea);
            end
        end
    end

    always @(negedge clk) begin
        if (ib.done === 1'b1) begin
            if (exp_b_q.size() == 0) begin
                check("unexpected_done_b", 1, 0);
            end else begin
                eb = exp_b_q.pop_front();
                check("result_b", {ib.overflow, ib.bcd_out, ib.hex_out}, eb);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic run_a(input logic [7:0] v, input logic bl, input logic [33:0] e, input int poke_at);
        int n;
        exp_a_q.push_back(e);
        @(negedge clk);
        ia.start = 1'b1; ia.bin_in = v; ia.blank_en = bl;
        @(negedge clk);
        ia.start = 1'b0; ia.bin_in = ~v; ia.blank_en = ~bl;
        n = 0;
        while (ia.busy && n < 40) begin
            n++;
            if (n == poke_at) begin
                ia.start = 1'b1; ia.bin_in = 8'hAA;
            end else begin
                ia.start = 1'b0;
            end
            @(negedge clk);
        end
        ia.start = 1'b0;
        check("busy_cycles_a", n, 8);
        check("done_after_busy_a", ia.done, 1);
        @(negedge clk);
    endtask

    task automatic run_b(input logic [9:0] v, input logic bl, input logic [22:0] e);
        int n;
        exp_b_q.push_back(e);
        @(negedge clk);
        ib.start = 1'b1; ib.bin_in = v; ib.blank_en = bl;
        @(negedge clk);
        ib.start = 1'b0; ib.bin_in = ~v;
        n = 0;
        while (ib.busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles_b", n, 10);
        check("done_after_busy_b", ib.done, 1);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t, d1, d2, dn;
        logic released;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        ia.start = 1'b0; ia.bin_in = '0; ia.blank_en = 1'b0;
        ib.start = 1'b0; ib.bin_in = '0; ib.blank_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy_a", ia.busy, 0);
        check("rst_done_a", ia.done, 0);
        check("rst_ovf_a", ia.overflow, 0);
        check("rst_bcd_a", ia.bcd_out, 0);
        check("rst_hex_a", ia.hex_out, 21'h1FFFFF);
        check("rst_hex_b", ib.hex_out, 14'h3FFF);
        rst_n = 1'b1;

        // 255: plain three-digit result
        run_a(8'd255, 1'b0, {1'b0, 12'h255, 7'b0100100, 7'b0010010, 7'b0010010}, -1);

        // reset in the middle of a conversion of 200
        @(negedge clk);
        ia.start = 1'b1; ia.bin_in = 8'd200; ia.blank_en = 1'b0;
        @(negedge clk);
        ia.start = 1'b0;
        repeat (3) @(negedge clk);
        check("midconv_busy_before_rst", ia.busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", ia.busy, 0);
        check("midrst_done", ia.done, 0);
        check("midrst_bcd", ia.bcd_out, 0);
        check("midrst_hex", ia.hex_out, 21'h1FFFFF);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ia.done) dn++;
        end
        check("midrst_no_done", dn, 0);

        // blanking cases and a middle zero that must stay lit
        run_a(8'd7,   1'b1, {1'b0, 12'h007, 7'b1111111, 7'b1111111, 7'b1111000}, -1);
        run_a(8'd0,   1'b1, {1'b0, 12'h000, 7'b1111111, 7'b1111111, 7'b1000000}, -1);
        run_a(8'd100, 1'b1, {1'b0, 12'h100, 7'b1111001, 7'b1000000, 7'b1000000}, -1);
        run_a(8'd42,  1'b0, {1'b0, 12'h042, 7'b1000000, 7'b0011001, 7'b0100100}, -1);
        check("hold_bcd_a", ia.bcd_out, 12'h042);

        // start pulsed while busy is ignored
        run_a(8'd123, 1'b0, {1'b0, 12'h123, 7'b1111001, 7'b0100100, 7'b0110000}, 3);
        repeat (2) @(negedge clk);
        check("no_queued_start_a", ia.busy, 0);

        // start held high across done: second conversion starts right after
        exp_a_q.push_back({1'b0, 12'h009, 7'b1111111, 7'b1111111, 7'b0010000});
        exp_a_q.push_back({1'b0, 12'h250, 7'b0100100, 7'b0010010, 7'b1000000});
        @(negedge clk);
        ia.start = 1'b1; ia.bin_in = 8'd9; ia.blank_en = 1'b1;
        @(negedge clk);
        ia.bin_in = 8'd250; ia.blank_en = 1'b0;
        t = 0; d1 = -1; d2 = -1; released = 1'b0;
        while (d2 < 0 && t < 60) begin
            @(negedge clk);
            t++;
            if (ia.done) begin
                if (d1 < 0) d1 = t;
                else d2 = t;
            end
            if (d1 >= 0 && !released && ia.busy) begin
                ia.start = 1'b0;
                released = 1'b1;
            end
        end
        ia.start = 1'b0;
        check("b2b_first_done", d1, 8);
        check("b2b_period", d2 - d1, 9);
        repeat (3) @(negedge clk);
        check("b2b_idle_after", ia.busy, 0);

        // 10-bit / 2-digit instance: overflow and its boundary
        run_b(10'd1000, 1'b1, {1'b1, 8'h00, 7'b0111111, 7'b0111111});
        run_b(10'd99,   1'b1, {1'b0, 8'h99, 7'b0010000, 7'b0010000});
        run_b(10'd100,  1'b1, {1'b1, 8'h00, 7'b0111111, 7'b0111111});
        run_b(10'd5,    1'b1, {1'b0, 8'h05, 7'b1111111, 7'b0010010});
        run_b(10'd1023, 1'b0, {1'b1, 8'h23, 7'b0111111, 7'b0111111});
        check("hold_ovf_b", ib.overflow, 1);

        repeat (4) @(negedge clk);
        check("exp_a_drained", exp_a_q.size(), 0);
        check("exp_b_drained", exp_b_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
